ex_mem_stage_reg: RTL and testbench
===================================

// Module: ex_mem_stage_reg
// PURPOSE
//  Parametrised EX/MEM pipeline register for the MZNM core. Replaces the fixed
//  always-load buffer with valid/stall/flush control and a CCR save stack.
//  The stack holds flags for nested interrupts (up to FLAG_DEPTH deep) and
//  returns them to the ALU on RTI. Sits between the ALU stage and data memory.
// PARAMETERS
//  DATA_W     16  ALU result / store-data width
//  PC_W       32  program counter width
//  REG_AW     3   register-file address width
//  OPC_W      5   opcode width
//  CCR_W      4   condition-code register width
//  FLAG_DEPTH 4   CCR save-stack entries (>=1)
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous reset, active low
//  stall           in   1       hold all stage outputs this cycle
//  flush           in   1       insert bubble this cycle
//  in_valid        in   1       EX holds a real instruction
//  in_mem_read     in   1       memory read enable
//  in_mem_write    in   1       memory write enable
//  in_mem_to_reg   in   1       writeback source select
//  in_reg_write    in   1       register-file write enable
//  in_is_push      in   1       SP-decrement operation
//  in_push_pop     in   2       stack-op enable code
//  in_call_phase   in   2       CALL sequencing phase
//  in_ret_phase    in   2       RET sequencing phase
//  in_int_phase    in   2       INT sequencing phase (2'b11 = save flags)
//  in_opcode       in   OPC_W   opcode
//  in_pc           in   PC_W    PC carried for CALL/INT
//  in_alu          in   DATA_W  ALU result
//  in_store_data   in   DATA_W  read_data2 / store data
//  in_rd           in   REG_AW  destination register
//  in_ccr          in   CCR_W   live flags from ALU
//  ccr_pop         in   1       RTI consumes saved flags (1-cycle pulse)
//  out_*           out  (same)  registered copy of each in_* above, plus out_valid
//  out_saved_ccr   out  CCR_W   top of save stack (0 when empty)
//  out_saved_valid out  1       stack non-empty
//  out_depth       out  $clog2(FLAG_DEPTH+1)  entries in use
//  err_overflow    out  1       sticky: push attempted while full
//  err_underflow   out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): every out_* = 0, out_valid=0, stack empty, depth=0,
//    both error flags 0. Stack entries are also cleared to 0.
//  - Latency: 1 cycle. Priority per edge: flush > stall > load.
//  - load: every out_* <= in_*; out_valid <= in_valid.
//  - stall: every out_* holds; out_valid holds.
//  - flush: out_valid=0. All control and phase fields = 0. Data/pc/opcode/rd = 0.
//    Flush during stall still flushes.
//  - CCR push: on a load edge with in_valid=1 and in_int_phase==2'b11, in_ccr is
//    written at index depth and depth is incremented.
//    * No push on stall or flush, so each INT captured exactly once.
//    * Full (depth==FLAG_DEPTH): no write, depth holds, err_overflow <= 1.
//  - CCR pop: ccr_pop acts independent of stall/flush.
//    * Non-empty: depth decrements.
//    * Empty: no change, err_underflow <= 1.
//    * Consumer samples out_saved_ccr in the same cycle it asserts ccr_pop.
//  - Simultaneous push+pop (state judged pre-edge):
//    * Non-empty: top entry overwritten with in_ccr; depth unchanged; no error,
//      including when full.
//    * Empty: push proceeds, depth=1, err_underflow <= 1.
//  - out_saved_ccr = entry[depth-1] read combinationally from registered
//    storage; 0 when depth==0. out_saved_valid = (depth!=0).
//  - Error flags clear only on reset.
// STRUCTURE
//  - ex_mem_pkg: INT_SAVE=2'b11 and PHASE_IDLE=2'b00 phase encodings, default widths,
//    and a packed ex_mem_ctrl_t struct (the 5 control bits plus the 4 phase fields).
//  - Sub-module ccr_save_stack: parameters CCR_W, FLAG_DEPTH; ports push, pop,
//    din, top, depth, ovf, udf.
//  - Top level = pipeline register with valid/stall/flush, plus one stack instance.
// TESTING
//  1 Reset mid-run: drive values, pull rst_n low between edges -> all outputs 0
//    immediately, depth=0.
//  2 Load/stall/flush: load in_alu=16'h1234, rd=5, reg_write=1; stall 2 cycles
//    -> outputs hold. flush -> out_valid=0, out_reg_write=0, out_alu=0.
//  3 Push: INT with int_phase=11, ccr=4'hA, stalled 3 cycles -> depth=1 only
//    after the load edge. Same INT with flush=1 -> depth unchanged.
//  4 Nesting (FLAG_DEPTH=4): pushes 1,2,3,4,5 -> depth=4, top=4,
//    err_overflow=1. Pops x4 -> tops 4,3,2,1, then out_saved_valid=0.
//  5 Underflow and simultaneous events: pop on empty -> err_underflow=1,
//    depth=0. depth=2, top=3, push ccr=9 + pop -> depth=2, top=9.
//  6 Pop during stall: depth=1, stall=1, ccr_pop=1 -> depth=0 while out_* hold.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
//  Shared definitions for the MZNM EX/MEM stage register:
//   - default parameter widths
//   - sequencing-phase encodings (PHASE_IDLE, INT_SAVE)
//   - ex_mem_ctrl_t: the five control bits plus the four 2-bit phase/stack fields
//   - is_flag_save(): true when an instruction is the INT flag-save step
package ex_mem_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int PC_W_DEF       = 32;
    localparam int REG_AW_DEF     = 3;
    localparam int OPC_W_DEF      = 5;
    localparam int CCR_W_DEF      = 4;
    localparam int FLAG_DEPTH_DEF = 4;

    localparam logic [1:0] PHASE_IDLE = 2'b00;
    localparam logic [1:0] INT_SAVE   = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       is_push;
        logic [1:0] push_pop;
        logic [1:0] call_phase;
        logic [1:0] ret_phase;
        logic [1:0] int_phase;
    } ex_mem_ctrl_t;

    // A bubble carries no side effects: every control bit and phase is idle.
    localparam ex_mem_ctrl_t CTRL_BUBBLE = '{
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        is_push:    1'b0,
        push_pop:   PHASE_IDLE,
        call_phase: PHASE_IDLE,
        ret_phase:  PHASE_IDLE,
        int_phase:  PHASE_IDLE
    };

    function automatic logic is_flag_save(input logic valid, input logic [1:0] int_phase);
        return valid && (int_phase == INT_SAVE);
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_ccr_save_stack.sv
// ccr_save_stack
//  LIFO of saved condition codes for nested interrupts.
//  Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears entries too)
//   push        write din on top (ignored and flagged via ovf when full)
//   pop         drop the top entry (flagged via udf when empty)
//   din         flags to save
//   top         entry[depth-1], 0 when empty (combinational from storage)
//   depth       entries in use
//   ovf, udf    sticky error flags, cleared only by reset
//  push and pop together on a non-empty stack replace the top entry in place.
//  On an empty stack the push still happens but the pop is reported as udf.
module ccr_save_stack #(
    parameter int CCR_W      = 4,
    parameter int FLAG_DEPTH = 4,
    localparam int DW        = $clog2(FLAG_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CCR_W-1:0] din,
    output logic [CCR_W-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             ovf,
    output logic             udf
);

    logic [CCR_W-1:0] mem_q [FLAG_DEPTH];
    logic [CCR_W-1:0] mem_d [FLAG_DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en;
    logic [DW-1:0]    wr_idx;
    logic             empty, full;

    assign empty = (depth_q == '0);
    assign full  = (depth_q == DW'(FLAG_DEPTH));

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_idx  = depth_q;
        unique case ({push, pop})
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    wr_idx  = '0;
                    depth_d = DW'(1);
                    udf_d   = 1'b1;
                end else begin
                    // Replace top in place; depth unchanged even when full.
                    wr_idx = depth_q - DW'(1);
                end
            end
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    depth_d = depth_q - DW'(1);
                end
            end
            default: ;
        endcase

        for (int i = 0; i < FLAG_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_idx == DW'(i))) begin
                mem_d[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            for (int i = 0; i < FLAG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            for (int i = 0; i < FLAG_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Select by comparing depth against each slot so no index can run past the array.
    always_comb begin
        top = '0;
        for (int i = 0; i < FLAG_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
//  EX/MEM pipeline register for the MZNM core with valid/stall/flush control
//  and a CCR save stack for nested interrupts.
//  Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   stall, flush         hold / bubble; flush wins over stall, stall over load
//   in_*                 EX-stage instruction fields
//   out_*                registered copies of in_* (1-cycle latency), out_valid
//   ccr_pop              RTI consumes the top saved flags (acts regardless of stall/flush)
//   out_saved_ccr        top of save stack, 0 when empty
//   out_saved_valid      save stack non-empty
//   out_depth            save-stack entries in use
//   err_overflow/_underflow  sticky stack errors
//  Flags are pushed only on a load edge, so an INT stalled for several cycles
//  is captured exactly once and a flushed INT is never captured.
module ex_mem_stage_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int OPC_W      = OPC_W_DEF,
    parameter int CCR_W      = CCR_W_DEF,
    parameter int FLAG_DEPTH = FLAG_DEPTH_DEF,
    localparam int DW        = $clog2(FLAG_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic              in_is_push,
    input  logic [1:0]        in_push_pop,
    input  logic [1:0]        in_call_phase,
    input  logic [1:0]        in_ret_phase,
    input  logic [1:0]        in_int_phase,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [CCR_W-1:0]  in_ccr,
    input  logic              ccr_pop,
    output logic              out_valid,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_reg_write,
    output logic              out_is_push,
    output logic [1:0]        out_push_pop,
    output logic [1:0]        out_call_phase,
    output logic [1:0]        out_ret_phase,
    output logic [1:0]        out_int_phase,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic [CCR_W-1:0]  out_ccr,
    output logic [CCR_W-1:0]  out_saved_ccr,
    output logic              out_saved_valid,
    output logic [DW-1:0]     out_depth,
    output logic              err_overflow,
    output logic              err_underflow
);

    ex_mem_ctrl_t      in_ctrl;
    ex_mem_ctrl_t      ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [CCR_W-1:0]  ccr_q, ccr_d;
    logic              load;
    logic              ccr_push;

    always_comb begin
        in_ctrl            = CTRL_BUBBLE;
        in_ctrl.mem_read   = in_mem_read;
        in_ctrl.mem_write  = in_mem_write;
        in_ctrl.mem_to_reg = in_mem_to_reg;
        in_ctrl.reg_write  = in_reg_write;
        in_ctrl.is_push    = in_is_push;
        in_ctrl.push_pop   = in_push_pop;
        in_ctrl.call_phase = in_call_phase;
        in_ctrl.ret_phase  = in_ret_phase;
        in_ctrl.int_phase  = in_int_phase;
    end

    assign load     = !flush && !stall;
    assign ccr_push = load && is_flag_save(in_valid, in_int_phase);

    always_comb begin
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        pc_d     = pc_q;
        alu_d    = alu_q;
        store_d  = store_q;
        rd_d     = rd_q;
        ccr_d    = ccr_q;
        if (flush) begin
            ctrl_d   = CTRL_BUBBLE;
            valid_d  = 1'b0;
            opcode_d = '0;
            pc_d     = '0;
            alu_d    = '0;
            store_d  = '0;
            rd_d     = '0;
            ccr_d    = '0;
        end else if (load) begin
            ctrl_d   = in_ctrl;
            valid_d  = in_valid;
            opcode_d = in_opcode;
            pc_d     = in_pc;
            alu_d    = in_alu;
            store_d  = in_store_data;
            rd_d     = in_rd;
            ccr_d    = in_ccr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= CTRL_BUBBLE;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            pc_q     <= '0;
            alu_q    <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            ccr_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            pc_q     <= pc_d;
            alu_q    <= alu_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            ccr_q    <= ccr_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_is_push    = ctrl_q.is_push;
    assign out_push_pop   = ctrl_q.push_pop;
    assign out_call_phase = ctrl_q.call_phase;
    assign out_ret_phase  = ctrl_q.ret_phase;
    assign out_int_phase  = ctrl_q.int_phase;
    assign out_opcode     = opcode_q;
    assign out_pc         = pc_q;
    assign out_alu        = alu_q;
    assign out_store_data = store_q;
    assign out_rd         = rd_q;
    assign out_ccr        = ccr_q;

    ccr_save_stack #(
        .CCR_W      (CCR_W),
        .FLAG_DEPTH (FLAG_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ccr_push),
        .pop   (ccr_pop),
        .din   (in_ccr),
        .top   (out_saved_ccr),
        .depth (out_depth),
        .ovf   (err_overflow),
        .udf   (err_underflow)
    );

    assign out_saved_valid = (out_depth != '0);

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;
  localparam int DATA_W = 16;
  localparam int PC_W = 32;
  localparam int REG_AW = 3;
  localparam int OPC_W = 5;
  localparam int CCR_W = 4;
  localparam int FLAG_DEPTH = 4;
  localparam int DW = $clog2(FLAG_DEPTH + 1);
  localparam int PW = 1 + 5 + 8 + OPC_W + PC_W + 2 * DATA_W + REG_AW + CCR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic stall, flush, in_valid, in_mem_read, in_mem_write, in_mem_to_reg;
  logic in_reg_write, in_is_push, ccr_pop;
  logic [1:0] in_push_pop, in_call_phase, in_ret_phase, in_int_phase;
  logic [OPC_W-1:0] in_opcode;
  logic [PC_W-1:0] in_pc;
  logic [DATA_W-1:0] in_alu, in_store_data;
  logic [REG_AW-1:0] in_rd;
  logic [CCR_W-1:0] in_ccr;

  logic out_valid, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write, out_is_push;
  logic [1:0] out_push_pop, out_call_phase, out_ret_phase, out_int_phase;
  logic [OPC_W-1:0] out_opcode;
  logic [PC_W-1:0] out_pc;
  logic [DATA_W-1:0] out_alu, out_store_data;
  logic [REG_AW-1:0] out_rd;
  logic [CCR_W-1:0] out_ccr, out_saved_ccr;
  logic out_saved_valid, err_overflow, err_underflow;
  logic [DW-1:0] out_depth;

  ex_mem_stage_reg #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .OPC_W(OPC_W),
    .CCR_W(CCR_W), .FLAG_DEPTH(FLAG_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_is_push(in_is_push),
    .in_push_pop(in_push_pop), .in_call_phase(in_call_phase), .in_ret_phase(in_ret_phase),
    .in_int_phase(in_int_phase), .in_opcode(in_opcode), .in_pc(in_pc), .in_alu(in_alu),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_ccr(in_ccr), .ccr_pop(ccr_pop),
    .out_valid(out_valid), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write), .out_is_push(out_is_push),
    .out_push_pop(out_push_pop), .out_call_phase(out_call_phase), .out_ret_phase(out_ret_phase),
    .out_int_phase(out_int_phase), .out_opcode(out_opcode), .out_pc(out_pc), .out_alu(out_alu),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_ccr(out_ccr),
    .out_saved_ccr(out_saved_ccr), .out_saved_valid(out_saved_valid), .out_depth(out_depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // ---------------- counters and check helper ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] in_vec();
    return {in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write, in_is_push,
            in_push_pop, in_call_phase, in_ret_phase, in_int_phase, in_opcode, in_pc,
            in_alu, in_store_data, in_rd, in_ccr};
  endfunction

  function automatic logic [PW-1:0] out_vec();
    return {out_valid, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write, out_is_push,
            out_push_pop, out_call_phase, out_ret_phase, out_int_phase, out_opcode, out_pc,
            out_alu, out_store_data, out_rd, out_ccr};
  endfunction

  // ---------------- reference model ----------------
  // Pipeline: one registered bundle. Stack: a queue whose back is the top.
  logic [PW-1:0] exp_pipe;
  logic [CCR_W-1:0] exp_q[$];
  logic m_ovf, m_udf, m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_pipe = '0;
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_push = in_valid && (in_int_phase == 2'b11) && !stall && !flush;
      m_pop = ccr_pop;
      if (m_push && m_pop) begin
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = in_ccr;
        else begin
          exp_q.push_back(in_ccr);
          m_udf = 1'b1;
        end
      end else if (m_push) begin
        if (exp_q.size() == FLAG_DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(in_ccr);
      end else if (m_pop) begin
        if (exp_q.size() == 0) m_udf = 1'b1;
        else void'(exp_q.pop_back());
      end
      if (flush) exp_pipe = '0;
      else if (!stall) exp_pipe = in_vec();
    end
  end

  function automatic logic [CCR_W-1:0] model_top();
    if (exp_q.size() == 0) return '0;
    return exp_q[exp_q.size() - 1];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pipe", out_vec(), exp_pipe);
      chk("depth", out_depth, exp_q.size());
      chk("saved_ccr", out_saved_ccr, model_top());
      chk("saved_valid", out_saved_valid, exp_q.size() != 0);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_underflow", err_underflow, m_udf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0; in_mem_read = 0; in_mem_write = 0;
    in_mem_to_reg = 0; in_reg_write = 0; in_is_push = 0; ccr_pop = 0;
    in_push_pop = 0; in_call_phase = 0; in_ret_phase = 0; in_int_phase = 0;
    in_opcode = 0; in_pc = 0; in_alu = 0; in_store_data = 0; in_rd = 0; in_ccr = 0;
  endtask

  task automatic rand_inputs(input int pop_den);
    in_valid = ($urandom_range(0, 3) != 0);
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
    in_mem_read = $urandom_range(0, 1);
    in_mem_write = $urandom_range(0, 1);
    in_mem_to_reg = $urandom_range(0, 1);
    in_reg_write = $urandom_range(0, 1);
    in_is_push = $urandom_range(0, 1);
    in_push_pop = $urandom_range(0, 3);
    in_call_phase = $urandom_range(0, 3);
    in_ret_phase = $urandom_range(0, 3);
    in_int_phase = $urandom_range(0, 3);
    in_opcode = $urandom;
    in_pc = $urandom;
    in_alu = $urandom;
    in_store_data = $urandom;
    in_rd = $urandom;
    in_ccr = $urandom;
    ccr_pop = ($urandom_range(0, pop_den - 1) == 0);
  endtask

  task automatic push_ccr(input logic [CCR_W-1:0] v);
    idle_inputs();
    in_valid = 1; in_int_phase = 2'b11; in_ccr = v;
    step();
    idle_inputs();
  endtask

  task automatic pop_once();
    idle_inputs();
    ccr_pop = 1;
    step();
    idle_inputs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    step();
    step();
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_depth", out_depth, 0);
    rst_n = 1;
    step();

    // Load, stall twice, then flush while stalled.
    in_valid = 1; in_alu = 16'h1234; in_rd = 5; in_reg_write = 1;
    step();
    chk("load_alu", out_alu, 16'h1234);
    chk("load_rd", out_rd, 5);
    chk("load_valid", out_valid, 1'b1);
    in_alu = 16'hBEEF; in_rd = 2; stall = 1;
    step();
    step();
    chk("stall_alu", out_alu, 16'h1234);
    chk("stall_reg_write", out_reg_write, 1'b1);
    flush = 1;
    step();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_reg_write", out_reg_write, 1'b0);
    chk("flush_alu", out_alu, 0);
    idle_inputs();

    // INT held by stall is pushed once, only on its load edge; flushed INT is never pushed.
    in_valid = 1; in_int_phase = 2'b11; in_ccr = 4'hA; stall = 1;
    repeat (3) step();
    chk("int_stalled_depth", out_depth, 0);
    stall = 0;
    step();
    chk("int_load_depth", out_depth, 1);
    chk("int_load_top", out_saved_ccr, 4'hA);
    flush = 1;
    step();
    chk("int_flush_depth", out_depth, 1);
    pop_once();
    chk("int_pop_depth", out_depth, 0);

    // Nesting to full and overflow, then drain.
    for (int v = 1; v <= 5; v++) push_ccr(v[CCR_W-1:0]);
    chk("nest_depth", out_depth, 4);
    chk("nest_top", out_saved_ccr, 4'h4);
    chk("nest_ovf", err_overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_top", out_saved_ccr, 4 - k);
      pop_once();
    end
    chk("drain_saved_valid", out_saved_valid, 1'b0);

    // Underflow, then push+pop on a non-empty stack replaces the top.
    pop_once();
    chk("udf_flag", err_underflow, 1'b1);
    chk("udf_depth", out_depth, 0);
    push_ccr(4'h2);
    push_ccr(4'h3);
    chk("pre_swap_depth", out_depth, 2);
    chk("pre_swap_top", out_saved_ccr, 4'h3);
    in_valid = 1; in_int_phase = 2'b11; in_ccr = 4'h9; ccr_pop = 1;
    step();
    idle_inputs();
    chk("swap_depth", out_depth, 2);
    chk("swap_top", out_saved_ccr, 4'h9);

    // Pop while stalled: stack moves, stage outputs hold.
    pop_once();
    in_valid = 1; in_alu = 16'h5555;
    step();
    in_alu = 16'hAAAA; stall = 1; ccr_pop = 1;
    step();
    idle_inputs();
    chk("stall_pop_depth", out_depth, 0);
    chk("stall_pop_alu", out_alu, 16'h5555);

    // Randomized traffic: push-heavy first, pop-heavy second.
    for (int n = 0; n < 1500; n++) begin
      rand_inputs(n < 750 ? 8 : 3);
      step();
    end

    // Asynchronous reset between clock edges.
    rand_inputs(4);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_pipe", out_vec(), 0);
    chk("async_rst_depth", out_depth, 0);
    chk("async_rst_saved", {out_saved_valid, out_saved_ccr}, 0);
    chk("async_rst_err", {err_overflow, err_underflow}, 2'b00);
    step();
    rst_n = 1;
    for (int n = 0; n < 200; n++) begin
      rand_inputs(4);
      step();
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
